// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Arbitrates the I/S/A/F ALU RAM channels onto one synchronous RAM
//            port, with a read-modify-write lock for the atomic channel.
//            Define RAM_ARB_RR_EN for round robin; default is I > S > A > F.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRAM_CE_I,
  input  logic              iRAM_CE_S,
  input  logic              iRAM_CE_A,
  input  logic              iRAM_CE_F,
  input  logic              iRAM_RD_I,
  input  logic              iRAM_RD_S,
  input  logic              iRAM_RD_A,
  input  logic              iRAM_RD_F,
  input  logic              iRAM_WR_I,
  input  logic              iRAM_WR_S,
  input  logic              iRAM_WR_A,
  input  logic              iRAM_WR_F,
  input  logic [ADDR_W-1:0] iRAM_ADDR_I,
  input  logic [ADDR_W-1:0] iRAM_ADDR_S,
  input  logic [ADDR_W-1:0] iRAM_ADDR_A,
  input  logic [ADDR_W-1:0] iRAM_ADDR_F,
  input  logic [DATA_W-1:0] iRAM_DATA_WR_I,
  input  logic [DATA_W-1:0] iRAM_DATA_WR_S,
  input  logic [DATA_W-1:0] iRAM_DATA_WR_A,
  input  logic [DATA_W-1:0] iRAM_DATA_WR_F,
  input  logic              iLOCK_A,
  output logic [DATA_W-1:0] oRAM_DATA_RD_I,
  output logic [DATA_W-1:0] oRAM_DATA_RD_S,
  output logic [DATA_W-1:0] oRAM_DATA_RD_A,
  output logic [DATA_W-1:0] oRAM_DATA_RD_F,
  output logic              oACK_I,
  output logic              oACK_S,
  output logic              oACK_A,
  output logic              oACK_F,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [DATA_W-1:0] oRAM_DATA,
  input  logic [DATA_W-1:0] iRAM_DATA,
  output logic [1:0]        oGNT,
  output logic              oBUSY,
  output logic              oLOCK_ERR
);

  localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DONE   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_gnt;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data [4];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_lock_err;

  logic [3:0]        w_req;
  logic [3:0]        w_rd;
  logic [3:0]        w_wr;
  logic [ADDR_W-1:0] w_addr [4];
  logic [DATA_W-1:0] w_wdata [4];
  logic [1:0]        w_pick;
  logic              w_grant;
  logic [1:0]        w_grant_idx;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_lock_to;
  logic              w_issue;
  logic              w_done;
  logic [3:0]        w_ack;
  logic [DATA_W-1:0] w_rd_out [4];

  assign w_rd  = {iRAM_RD_F, iRAM_RD_A, iRAM_RD_S, iRAM_RD_I};
  assign w_wr  = {iRAM_WR_F, iRAM_WR_A, iRAM_WR_S, iRAM_WR_I};
  assign w_req = {iRAM_CE_F, iRAM_CE_A, iRAM_CE_S, iRAM_CE_I} & (w_rd | w_wr);

  assign w_addr[0]  = iRAM_ADDR_I;
  assign w_addr[1]  = iRAM_ADDR_S;
  assign w_addr[2]  = iRAM_ADDR_A;
  assign w_addr[3]  = iRAM_ADDR_F;
  assign w_wdata[0] = iRAM_DATA_WR_I;
  assign w_wdata[1] = iRAM_DATA_WR_S;
  assign w_wdata[2] = iRAM_DATA_WR_A;
  assign w_wdata[3] = iRAM_DATA_WR_F;

`ifdef RAM_ARB_RR_EN
  logic [1:0] r_last;
  logic [1:0] w_idx;
  logic       w_found;

  // Scan starts just after the last grant; k=4 wraps back to r_last itself.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_idx   = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && w_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_last <= 2'd3;
    end else if (w_grant) begin
      r_last <= w_grant_idx;
    end
  end
`else
  always_comb begin
    w_pick = 2'd3;
    if (w_req[2]) w_pick = 2'd2;
    if (w_req[1]) w_pick = 2'd1;
    if (w_req[0]) w_pick = 2'd0;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_idx = r_gnt;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_lock_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant     = 1'b1;
          w_grant_idx = w_pick;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_DONE;
      S_DONE: begin
        if ((r_gnt == 2'd2) && iLOCK_A) begin
          w_state_nxt = S_LOCKED;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (w_req[2]) begin
          w_grant     = 1'b1;
          w_grant_idx = 2'd2;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (!iLOCK_A) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_lock_to   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_lock_err <= 1'b0;
      for (int k = 0; k < 4; k++) r_rd_data[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      // RD with WR executes as a write, and reads drive zero write data.
      if (w_grant) begin
        r_gnt   <= w_grant_idx;
        r_addr  <= w_addr[w_grant_idx];
        r_wr    <= w_wr[w_grant_idx];
        r_rd    <= w_rd[w_grant_idx] & ~w_wr[w_grant_idx];
        r_wdata <= w_wr[w_grant_idx] ? w_wdata[w_grant_idx] : '0;
      end
      if (w_done && r_rd) r_rd_data[r_gnt] <= iRAM_DATA;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_lock_to) r_lock_err <= 1'b1;
    end
  end

  assign w_issue   = (r_state == S_ISSUE);
  assign w_done    = (r_state == S_DONE);
  assign w_ack     = w_done ? (4'b0001 << r_gnt) : 4'b0000;

  assign oRAM_CE   = w_issue;
  assign oRAM_RD   = w_issue & r_rd;
  assign oRAM_WR   = w_issue & r_wr;
  assign oRAM_ADDR = r_addr;
  assign oRAM_DATA = r_wdata;
  assign oGNT      = r_gnt;
  assign oBUSY     = (r_state != S_IDLE);
  assign oLOCK_ERR = r_lock_err;

  assign oACK_I    = w_ack[0];
  assign oACK_S    = w_ack[1];
  assign oACK_A    = w_ack[2];
  assign oACK_F    = w_ack[3];

  // RAM data arrives in DONE; forward it alongside the ack, then hold it.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_rd_out
      assign w_rd_out[g] = (w_ack[g] && r_rd) ? iRAM_DATA : r_rd_data[g];
    end
  endgenerate

  assign oRAM_DATA_RD_I = w_rd_out[0];
  assign oRAM_DATA_RD_S = w_rd_out[1];
  assign oRAM_DATA_RD_A = w_rd_out[2];
  assign oRAM_DATA_RD_F = w_rd_out[3];

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed, table-driven checks of ram_port_arbiter with a small
//            synchronous RAM read model. Honors RAM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ce = '0;
  logic [3:0]  rd = '0;
  logic [3:0]  wr = '0;
  logic [7:0]  addr_v [4];
  logic [31:0] wdata_v [4];
  logic        lock_a = 1'b0;
  logic [31:0] rdata_i, rdata_s, rdata_a, rdata_f;
  logic [3:0]  ack;
  logic        ram_ce, ram_rd, ram_wr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  gnt;
  logic        busy, lock_err;
  logic [7:0]  rd_addr_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Synchronous RAM: data for the address read in ISSUE appears during DONE.
  always @(posedge clk) if (ram_ce && ram_rd) rd_addr_q <= ram_addr;
  assign ram_rdata = (rd_addr_q == 8'h10) ? 32'hDEADBEEF : {24'h5A5A5A, rd_addr_q};

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LOCK_TIMEOUT(4)) dut (
    .iCLK(clk), .iRST(rst_n),
    .iRAM_CE_I(ce[0]), .iRAM_CE_S(ce[1]), .iRAM_CE_A(ce[2]), .iRAM_CE_F(ce[3]),
    .iRAM_RD_I(rd[0]), .iRAM_RD_S(rd[1]), .iRAM_RD_A(rd[2]), .iRAM_RD_F(rd[3]),
    .iRAM_WR_I(wr[0]), .iRAM_WR_S(wr[1]), .iRAM_WR_A(wr[2]), .iRAM_WR_F(wr[3]),
    .iRAM_ADDR_I(addr_v[0]), .iRAM_ADDR_S(addr_v[1]),
    .iRAM_ADDR_A(addr_v[2]), .iRAM_ADDR_F(addr_v[3]),
    .iRAM_DATA_WR_I(wdata_v[0]), .iRAM_DATA_WR_S(wdata_v[1]),
    .iRAM_DATA_WR_A(wdata_v[2]), .iRAM_DATA_WR_F(wdata_v[3]),
    .iLOCK_A(lock_a),
    .oRAM_DATA_RD_I(rdata_i), .oRAM_DATA_RD_S(rdata_s),
    .oRAM_DATA_RD_A(rdata_a), .oRAM_DATA_RD_F(rdata_f),
    .oACK_I(ack[0]), .oACK_S(ack[1]), .oACK_A(ack[2]), .oACK_F(ack[3]),
    .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr),
    .oRAM_ADDR(ram_addr), .oRAM_DATA(ram_wdata), .iRAM_DATA(ram_rdata),
    .oGNT(gnt), .oBUSY(busy), .oLOCK_ERR(lock_err)
  );

  typedef struct {
    int          ch;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];
  int   exp_idx [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ce = '0; rd = '0; wr = '0; lock_a = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] get_rdata(input int ch);
    case (ch)
      0:       return rdata_i;
      1:       return rdata_s;
      2:       return rdata_a;
      default: return rdata_f;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr_v[k]  = '0;
      wdata_v[k] = '0;
    end
    vecs[0] = '{0, 1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1, 1'b0, 1'b1, 8'h33, 32'h11112222, 1'b0, 1'b1, 32'h11112222, 32'h0};
    vecs[2] = '{2, 1'b1, 1'b0, 8'h44, 32'h0,        1'b1, 1'b0, 32'h0,        32'h5A5A5A44};
    vecs[3] = '{3, 1'b1, 1'b1, 8'h55, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 32'h0};
    vecs[4] = '{3, 1'b1, 1'b0, 8'h66, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        32'h5A5A5A66};
    vecs[5] = '{1, 1'b1, 1'b0, 8'h77, 32'h0,        1'b1, 1'b0, 32'h0,        32'h5A5A5A77};
`ifdef RAM_ARB_RR_EN
    exp_idx = '{0, 1, 2, 3};
`else
    exp_idx = '{0, 0, 0, 0};
`endif

    // Reset state
    tick();
    tick();
    chk("rst ack", {28'h0, ack}, 32'h0);
    chk("rst ram_ce", {31'h0, ram_ce}, 32'h0);
    chk("rst ram_rd", {31'h0, ram_rd}, 32'h0);
    chk("rst ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst lock_err", {31'h0, lock_err}, 32'h0);
    chk("rst gnt", {30'h0, gnt}, 32'h0);
    chk("rst addr", {24'h0, ram_addr}, 32'h0);
    chk("rst wdata", ram_wdata, 32'h0);
    chk("rst rdata", rdata_i | rdata_s | rdata_a | rdata_f, 32'h0);
    rst_n = 1'b1;

    // Single-channel accesses; CE drops right after grant and the access still completes
    for (int v = 0; v < 6; v++) begin
      int ch;
      ch = vecs[v].ch;
      ce[ch] = 1'b1; rd[ch] = vecs[v].rd; wr[ch] = vecs[v].wr;
      addr_v[ch] = vecs[v].addr; wdata_v[ch] = vecs[v].wdata;
      tick();
      chk($sformatf("v%0d issue ce", v), {31'h0, ram_ce}, 32'h1);
      chk($sformatf("v%0d issue rd", v), {31'h0, ram_rd}, {31'h0, vecs[v].exp_rd});
      chk($sformatf("v%0d issue wr", v), {31'h0, ram_wr}, {31'h0, vecs[v].exp_wr});
      chk($sformatf("v%0d issue addr", v), {24'h0, ram_addr}, {24'h0, vecs[v].addr});
      chk($sformatf("v%0d issue data", v), ram_wdata, vecs[v].exp_data);
      chk($sformatf("v%0d issue gnt", v), {30'h0, gnt}, ch);
      chk($sformatf("v%0d issue ack", v), {28'h0, ack}, 32'h0);
      ce[ch] = 1'b0;
      tick();
      chk($sformatf("v%0d done ack", v), {28'h0, ack}, 32'h1 << ch);
      chk($sformatf("v%0d done ram_ce", v), {31'h0, ram_ce}, 32'h0);
      chk($sformatf("v%0d done rdata", v), get_rdata(ch), vecs[v].exp_rdata);
      tick();
      chk($sformatf("v%0d idle busy", v), {31'h0, busy}, 32'h0);
      chk($sformatf("v%0d idle ack", v), {28'h0, ack}, 32'h0);
      chk($sformatf("v%0d hold rdata", v), get_rdata(ch), vecs[v].exp_rdata);
      rd[ch] = 1'b0; wr[ch] = 1'b0;
    end

    // All four request together; I keeps re-requesting, others drop after their ack
    do_reset();
    ce = 4'hF; rd = 4'hF; wr = 4'h0;
    for (int k = 0; k < 4; k++) addr_v[k] = 8'(k + 1);
    for (int c = 1; c <= 12; c++) begin
      logic [3:0] exp_ack;
      tick();
      exp_ack = 4'h0;
      if (c % 3 == 2) exp_ack = 4'h1 << exp_idx[(c - 2) / 3];
      if (c % 3 == 1)
        chk($sformatf("all c%0d gnt", c), {30'h0, gnt}, exp_idx[(c - 1) / 3]);
      chk($sformatf("all c%0d ack", c), {28'h0, ack}, {28'h0, exp_ack});
      ce = ce & ~(exp_ack & 4'b1110);
    end
    ce = '0; rd = '0;

    // Atomic lock: A holds the port across read then write while S waits
    tick();
    ce[2] = 1'b1; rd[2] = 1'b1; addr_v[2] = 8'h30; lock_a = 1'b1;
    tick();
    chk("lock issue gnt", {30'h0, gnt}, 32'h2);
    ce[1] = 1'b1; wr[1] = 1'b1; addr_v[1] = 8'h40; wdata_v[1] = 32'hAAAA5555;
    tick();
    chk("lock rd ack", {28'h0, ack}, 32'h4);
    chk("lock rd data", rdata_a, 32'h5A5A5A30);
    rd[2] = 1'b0; wr[2] = 1'b1; addr_v[2] = 8'h20; wdata_v[2] = 32'hCAFEF00D;
    tick();
    chk("locked busy", {31'h0, busy}, 32'h1);
    chk("locked ram_ce", {31'h0, ram_ce}, 32'h0);
    tick();
    chk("lock wr gnt", {30'h0, gnt}, 32'h2);
    chk("lock wr strobe", {30'h0, ram_wr, ram_ce}, 32'h3);
    chk("lock wr addr", {24'h0, ram_addr}, 32'h20);
    chk("lock wr data", ram_wdata, 32'hCAFEF00D);
    tick();
    chk("lock wr ack", {28'h0, ack}, 32'h4);
    ce[2] = 1'b0; wr[2] = 1'b0;
    tick();
    chk("lock hold ack", {28'h0, ack}, 32'h0);
    chk("lock hold ce", {31'h0, ram_ce}, 32'h0);
    lock_a = 1'b0;
    tick();
    chk("unlock idle", {31'h0, busy}, 32'h0);
    tick();
    chk("s after lock gnt", {30'h0, gnt}, 32'h1);
    chk("s after lock addr", {24'h0, ram_addr}, 32'h40);
    tick();
    chk("s after lock ack", {28'h0, ack}, 32'h2);
    chk("no lock err", {31'h0, lock_err}, 32'h0);
    ce[1] = 1'b0; wr[1] = 1'b0;

    // Lock timeout: four idle LOCKED cycles, then sticky error and S served
    tick();
    ce[2] = 1'b1; rd[2] = 1'b1; addr_v[2] = 8'h50; lock_a = 1'b1;
    tick();
    ce[1] = 1'b1; rd[1] = 1'b1; addr_v[1] = 8'h60;
    tick();
    chk("to a ack", {28'h0, ack}, 32'h4);
    ce[2] = 1'b0; rd[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to locked%0d busy", c), {31'h0, busy}, 32'h1);
      chk($sformatf("to locked%0d err", c), {31'h0, lock_err}, 32'h0);
    end
    tick();
    chk("to idle busy", {31'h0, busy}, 32'h0);
    chk("to err set", {31'h0, lock_err}, 32'h1);
    tick();
    chk("to s gnt", {30'h0, gnt}, 32'h1);
    tick();
    chk("to s ack", {28'h0, ack}, 32'h2);
    chk("to s data", rdata_s, 32'h5A5A5A60);
    chk("to err sticky", {31'h0, lock_err}, 32'h1);
    ce[1] = 1'b0; rd[1] = 1'b0; lock_a = 1'b0;

    // Reset asserted in ISSUE aborts the access; held request is re-served
    tick();
    ce[0] = 1'b1; rd[0] = 1'b1; addr_v[0] = 8'h10;
    tick();
    chk("rsti issue ce", {31'h0, ram_ce}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsti ram_ce", {31'h0, ram_ce}, 32'h0);
    chk("rsti busy", {31'h0, busy}, 32'h0);
    chk("rsti err clr", {31'h0, lock_err}, 32'h0);
    tick();
    chk("rsti ack0", {28'h0, ack}, 32'h0);
    tick();
    chk("rsti ack1", {28'h0, ack}, 32'h0);
    chk("rsti rdata", rdata_i, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rsti reissue rd", {30'h0, ram_rd, ram_ce}, 32'h3);
    chk("rsti reissue addr", {24'h0, ram_addr}, 32'h10);
    tick();
    chk("rsti reissue ack", {28'h0, ack}, 32'h1);
    chk("rsti reissue data", rdata_i, 32'hDEADBEEF);
    ce[0] = 1'b0; rd[0] = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
